// File: rtl/ex_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_wb_pkg
//  Purpose  : Shared types for the EX->WB skid stage: occupancy state
//             encoding, the payload carried from EX to WB, and the
//             write-back result select helper.
//  Revision : 1.0  initial release
// ============================================================================
package ex_wb_pkg;

   // Payload field widths; the stage parameters default to these values
   localparam int PAYLOAD_DATA_W = 8;
   localparam int PAYLOAD_REG_AW = 3;

   // Occupancy of the two-slot stage (EMPTY / main only / main + skid)
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   // One EX->WB entry as held in either slot
   typedef struct packed {
      logic [PAYLOAD_REG_AW-1:0] rs1;
      logic [PAYLOAD_REG_AW-1:0] rs2;
      logic [PAYLOAD_REG_AW-1:0] rd;
      logic [PAYLOAD_DATA_W-1:0] ext_data;
      logic [PAYLOAD_DATA_W-1:0] aluout;
      logic                      regwrite;
      logic                      wbsel;
   } ex_wb_payload_t;

   // Write-back result: external/load data when wbsel is set, else ALU result
   function automatic logic [PAYLOAD_DATA_W-1:0] wb_select(input ex_wb_payload_t p);
      return p.wbsel ? p.ext_data : p.aluout;
   endfunction

endpackage : ex_wb_pkg
`default_nettype wire

// File: rtl/ex_wb_skid_stage_stall_counter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stall_counter
//  Purpose  : Saturating up-counter with enable and asynchronous reset.
//             Counts back-pressure cycles for debug; sticks at all-ones.
//  Revision : 1.0  initial release
// ============================================================================
module wb_stall_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_count;

   // Increment while enabled, hold once saturated; only reset clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (en && (r_count != c_cnt_max)) begin
         r_count <= r_count + c_cnt_one;
      end
   end

   assign count = r_count;

endmodule : wb_stall_counter
`default_nettype wire

// File: rtl/ex_wb_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_wb_skid_stage
//  Purpose  : EX->WB pipeline boundary with valid/ready handshake, a
//             two-entry skid buffer (main + skid), synchronous flush, the
//             write-back result mux and a saturating back-pressure counter.
//             in_ready is registered so WB stalls never form a combinational
//             path back into EX.
//  Revision : 1.0  initial release
// ============================================================================
module ex_wb_skid_stage
   import ex_wb_pkg::*;
#(
   parameter int DATA_W      = PAYLOAD_DATA_W,
   parameter int REG_AW      = PAYLOAD_REG_AW,
   parameter bit ZERO_REG_WP = 1'b1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [REG_AW-1:0]      rs1,
   input  logic [REG_AW-1:0]      rs2,
   input  logic [REG_AW-1:0]      rd,
   input  logic [DATA_W-1:0]      ext_data,
   input  logic [DATA_W-1:0]      aluout,
   input  logic                   regwrite,
   input  logic                   wbsel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [REG_AW-1:0]      rs1_out,
   output logic [REG_AW-1:0]      rs2_out,
   output logic [REG_AW-1:0]      rd_out,
   output logic [DATA_W-1:0]      ext_data_out,
   output logic [DATA_W-1:0]      aluout_out,
   output logic                   wbsel_out,
   output logic                   regwrite_out,
   output logic [DATA_W-1:0]      wb_data,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   stage_state_e   r_state;
   stage_state_e   w_state_nxt;
   ex_wb_payload_t r_main;
   ex_wb_payload_t r_skid;
   ex_wb_payload_t w_in_payload;
   logic           r_in_ready;

   logic           w_main_valid;
   logic           w_accept;
   logic           w_consume;
   logic           w_load_main_in;
   logic           w_load_main_skid;
   logic           w_load_skid;
   logic           w_rd_is_zero;
   logic           w_stall_en;

   // Pack the EX inputs into one entry; only captured on accept
   assign w_in_payload = '{
      rs1:      rs1,
      rs2:      rs2,
      rd:       rd,
      ext_data: ext_data,
      aluout:   aluout,
      regwrite: regwrite,
      wbsel:    wbsel
   };

   // Slot valid bits are implied by the occupancy state
   assign w_main_valid = (r_state != ST_EMPTY);
   assign w_accept     = in_valid & r_in_ready;
   assign w_consume    = w_main_valid & out_ready;

   // ------------------------------------------------------------------
   // State register and registered in_ready
   // ------------------------------------------------------------------
   // in_ready for the next cycle is simply "skid will be empty"
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_TWO);
      end
   end

   // ------------------------------------------------------------------
   // Next-state and slot load controls; flush overrides everything
   // ------------------------------------------------------------------
   // Decide occupancy transition and which slot (if any) loads
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;

      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_load_main_in = 1'b1;
                  w_state_nxt    = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_consume) begin
                  w_load_main_in = 1'b1;
               end else if (w_accept) begin
                  w_load_skid = 1'b1;
                  w_state_nxt = ST_TWO;
               end else if (w_consume) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a consume can move us
               if (w_consume) begin
                  w_load_main_skid = 1'b1;
                  w_state_nxt      = ST_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Payload slots (stale after flush; outputs are qualified by valid)
   // ------------------------------------------------------------------
   // Main reloads from input or from skid; skid only ever loads from input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main <= w_in_payload;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_in_payload;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign w_rd_is_zero = (r_main.rd == '0);

   // Drive head entry, qualified write enable and write-back result
   always_comb begin
      in_ready     = r_in_ready;
      out_valid    = w_main_valid;
      rs1_out      = r_main.rs1;
      rs2_out      = r_main.rs2;
      rd_out       = r_main.rd;
      ext_data_out = r_main.ext_data;
      aluout_out   = r_main.aluout;
      wbsel_out    = r_main.wbsel;
      wb_data      = wb_select(r_main);
      regwrite_out = w_main_valid & r_main.regwrite & ~(ZERO_REG_WP & w_rd_is_zero);
   end

   // ------------------------------------------------------------------
   // Back-pressure debug counter
   // ------------------------------------------------------------------
   assign w_stall_en = w_main_valid & ~out_ready;

   wb_stall_counter #(
      .CNT_W (STALL_CNT_W)
   ) u_stall_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (w_stall_en),
      .count (stall_cnt)
   );

endmodule : ex_wb_skid_stage
`default_nettype wire

// File: tb/tb_ex_wb_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_wb_skid_stage
//  Purpose  : Self-checking bench for ex_wb_skid_stage. A queue-based model
//             of the stage is compared against two instances (16-bit and
//             4-bit stall counters) driven by the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_wb_skid_stage;

   logic       clk = 1'b0;
   logic       rst, flush, in_valid, out_ready, regwrite, wbsel;
   logic [2:0] rs1, rs2, rd;
   logic [7:0] ext_data, aluout;

   logic        a_in_ready, a_out_valid, a_wbsel_out, a_regwrite_out;
   logic [2:0]  a_rs1_out, a_rs2_out, a_rd_out;
   logic [7:0]  a_ext_out, a_alu_out, a_wb_data;
   logic [15:0] a_stall;

   logic        b_in_ready, b_out_valid, b_wbsel_out, b_regwrite_out;
   logic [2:0]  b_rs1_out, b_rs2_out, b_rd_out;
   logic [7:0]  b_ext_out, b_alu_out, b_wb_data;
   logic [3:0]  b_stall;

   always #5 clk = ~clk;

   ex_wb_skid_stage #(.DATA_W(8), .REG_AW(3), .ZERO_REG_WP(1'b1), .STALL_CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .rs1(rs1), .rs2(rs2), .rd(rd), .ext_data(ext_data), .aluout(aluout),
      .regwrite(regwrite), .wbsel(wbsel), .out_valid(a_out_valid), .out_ready(out_ready),
      .rs1_out(a_rs1_out), .rs2_out(a_rs2_out), .rd_out(a_rd_out),
      .ext_data_out(a_ext_out), .aluout_out(a_alu_out), .wbsel_out(a_wbsel_out),
      .regwrite_out(a_regwrite_out), .wb_data(a_wb_data), .stall_cnt(a_stall));

   ex_wb_skid_stage #(.DATA_W(8), .REG_AW(3), .ZERO_REG_WP(1'b1), .STALL_CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .rs1(rs1), .rs2(rs2), .rd(rd), .ext_data(ext_data), .aluout(aluout),
      .regwrite(regwrite), .wbsel(wbsel), .out_valid(b_out_valid), .out_ready(out_ready),
      .rs1_out(b_rs1_out), .rs2_out(b_rs2_out), .rd_out(b_rd_out),
      .ext_data_out(b_ext_out), .aluout_out(b_alu_out), .wbsel_out(b_wbsel_out),
      .regwrite_out(b_regwrite_out), .wb_data(b_wb_data), .stall_cnt(b_stall));

   // ---------------- reference model ----------------
   typedef struct {
      logic [2:0] rs1, rs2, rd;
      logic [7:0] ext, alu;
      logic       rw, ws;
   } ent_t;

   ent_t        q[$];
   bit          m_rdy;
   int unsigned m_stall;
   bit          m_acc_last;
   logic [7:0]  log_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rdy   = 1'b0;
      m_stall = 0;
   endtask

   task automatic check_inst(input string who, input logic ov, input logic ir,
                             input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] rdo,
                             input logic [7:0] ex, input logic [7:0] al, input logic ws,
                             input logic rw, input logic [7:0] wbd,
                             input logic [31:0] st, input logic [31:0] st_exp);
      chk({who, ".out_valid"}, 32'(ov), 32'(q.size() > 0));
      chk({who, ".in_ready"}, 32'(ir), 32'(m_rdy));
      chk({who, ".stall_cnt"}, st, st_exp);
      if (q.size() > 0) begin
         chk({who, ".rs1_out"}, 32'(r1), 32'(q[0].rs1));
         chk({who, ".rs2_out"}, 32'(r2), 32'(q[0].rs2));
         chk({who, ".rd_out"}, 32'(rdo), 32'(q[0].rd));
         chk({who, ".ext_data_out"}, 32'(ex), 32'(q[0].ext));
         chk({who, ".aluout_out"}, 32'(al), 32'(q[0].alu));
         chk({who, ".wbsel_out"}, 32'(ws), 32'(q[0].ws));
         chk({who, ".regwrite_out"}, 32'(rw), 32'(q[0].rw && (q[0].rd != 3'd0)));
         chk({who, ".wb_data"}, 32'(wbd), 32'(q[0].ws ? q[0].ext : q[0].alu));
      end else begin
         chk({who, ".regwrite_out_idle"}, 32'(rw), 32'd0);
      end
   endtask

   task automatic check_all();
      check_inst("a", a_out_valid, a_in_ready, a_rs1_out, a_rs2_out, a_rd_out, a_ext_out,
                 a_alu_out, a_wbsel_out, a_regwrite_out, a_wb_data, 32'(a_stall), m_stall);
      check_inst("b", b_out_valid, b_in_ready, b_rs1_out, b_rs2_out, b_rd_out, b_ext_out,
                 b_alu_out, b_wbsel_out, b_regwrite_out, b_wb_data, 32'(b_stall),
                 (m_stall > 15) ? 32'd15 : m_stall);
   endtask

   // One clock: predict from pre-edge inputs, step the model, check at edge+1
   task automatic cycle();
      bit   acc, con;
      ent_t e;
      acc = in_valid && m_rdy;
      con = (q.size() > 0) && out_ready;
      e   = '{rs1: rs1, rs2: rs2, rd: rd, ext: ext_data, alu: aluout, rw: regwrite, ws: wbsel};
      if (a_out_valid && out_ready) log_q.push_back(a_alu_out);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if ((q.size() > 0) && !out_ready && (m_stall < 32'hFFFF)) m_stall++;
         if (flush) begin
            q.delete();
         end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(e);
         end
         m_rdy = (q.size() < 2);
      end
      m_acc_last = acc && !flush && !rst;
      #1;
      check_all();
   endtask

   task automatic drive(input bit v, input logic [7:0] alu, input logic [7:0] ext,
                        input logic [2:0] d, input bit rw, input bit ws);
      in_valid = v;
      aluout   = alu;
      ext_data = ext;
      rd       = d;
      regwrite = rw;
      wbsel    = ws;
      rs1      = 3'($urandom);
      rs2      = 3'($urandom);
   endtask

   task automatic check_reset_zero(input string tag);
      chk({tag, ".in_ready"}, 32'(a_in_ready), 32'd0);
      chk({tag, ".out_valid"}, 32'(a_out_valid), 32'd0);
      chk({tag, ".regwrite_out"}, 32'(a_regwrite_out), 32'd0);
      chk({tag, ".payload"}, {5'd0, a_rs1_out, a_rs2_out, a_rd_out, a_ext_out, a_alu_out},
          32'd0);
      chk({tag, ".wbsel_out"}, 32'(a_wbsel_out), 32'd0);
      chk({tag, ".wb_data"}, 32'(a_wb_data), 32'd0);
      chk({tag, ".stall_cnt"}, 32'(a_stall), 32'd0);
      chk({tag, ".b_in_ready"}, 32'(b_in_ready), 32'd0);
      chk({tag, ".b_stall_cnt"}, 32'(b_stall), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      model_reset();
      #3;
      check_reset_zero("init_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      cycle();
      chk("release.in_ready", 32'(a_in_ready), 32'd1);

      // Streaming: 0x11..0x14 with out_ready held high
      out_ready = 1'b1;
      log_q.delete();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'h11 + i), 8'($urandom), 3'(i + 1), 1'b1, 1'b0);
         cycle();
      end
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      cycle(); cycle();
      chk("stream.count", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < log_q.size()) chk("stream.order", 32'(log_q[i]), 32'(8'h11 + i));
      chk("stream.stall_cnt", 32'(a_stall), 32'd0);

      // Back-pressure: A1, A2 accepted, A3 held, 5 stall cycles
      out_ready = 1'b0;
      log_q.delete();
      drive(1'b1, 8'hA1, 8'h01, 3'd1, 1'b1, 1'b0); cycle();
      drive(1'b1, 8'hA2, 8'h02, 3'd2, 1'b1, 1'b0); cycle();
      chk("bp.in_ready_drop", 32'(a_in_ready), 32'd0);
      drive(1'b1, 8'hA3, 8'h03, 3'd3, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      chk("bp.stall_cnt", 32'(a_stall), 32'd5);
      chk("bp.head_held", 32'(a_alu_out), 32'hA1);
      out_ready = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         cycle();
         done = m_acc_last;
      end
      chk("bp.a3_accepted", 32'(done), 32'd1);
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      chk("bp.count", 32'(log_q.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < log_q.size()) chk("bp.order", 32'(log_q[i]), 32'(8'hA1 + i));

      // Flush in TWO with an input presented in the same cycle
      out_ready = 1'b0;
      drive(1'b1, 8'hB1, 8'h00, 3'd1, 1'b1, 1'b0); cycle();
      drive(1'b1, 8'hB2, 8'h00, 3'd2, 1'b1, 1'b0); cycle();
      drive(1'b1, 8'hEE, 8'h00, 3'd4, 1'b1, 1'b0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      chk("flush.out_valid", 32'(a_out_valid), 32'd0);
      chk("flush.regwrite_out", 32'(a_regwrite_out), 32'd0);
      chk("flush.in_ready", 32'(a_in_ready), 32'd1);
      out_ready = 1'b1;
      cycle(); cycle();
      chk("flush.no_ghost", 32'(a_out_valid), 32'd0);

      // Write-back path
      out_ready = 1'b0;
      drive(1'b1, 8'h33, 8'h5C, 3'd3, 1'b1, 1'b1); cycle();
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      chk("wb.ext_select", 32'(a_wb_data), 32'h5C);
      chk("wb.rd3_regwrite", 32'(a_regwrite_out), 32'd1);
      out_ready = 1'b1; cycle();
      out_ready = 1'b0;
      drive(1'b1, 8'h33, 8'h5C, 3'd0, 1'b1, 1'b0); cycle();
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      chk("wb.alu_select", 32'(a_wb_data), 32'h33);
      chk("wb.rd0_suppressed", 32'(a_regwrite_out), 32'd0);
      out_ready = 1'b1; cycle();

      // Asynchronous reset with both slots occupied
      out_ready = 1'b0;
      drive(1'b1, 8'hC1, 8'h00, 3'd1, 1'b1, 1'b0); cycle();
      drive(1'b1, 8'hC2, 8'h00, 3'd2, 1'b1, 1'b1); cycle();
      chk("rst.pre_two", 32'(a_in_ready), 32'd0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_zero("rst_async");
      cycle();
      rst = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      cycle();
      chk("rst.release_in_ready", 32'(a_in_ready), 32'd1);

      // Stall counter saturation (4-bit instance)
      drive(1'b1, 8'hD1, 8'h00, 3'd1, 1'b1, 1'b0); cycle();
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle();
      chk("sat.b_stall_cnt", 32'(b_stall), 32'd15);
      chk("sat.a_stall_cnt", 32'(a_stall), 32'd20);
      cycle(); cycle();
      chk("sat.b_holds", 32'(b_stall), 32'd15);
      out_ready = 1'b1; cycle(); cycle();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
               1'($urandom));
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 31) == 0);
         cycle();
      end
      flush = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      chk("final.drained", 32'(a_out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ex_wb_skid_stage
`default_nettype wire
